// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and FSM state type.
package mdu_pkg;

  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: right-shifting shift-add for multiply,
// left-shifting restoring trial subtract for divide. {hi,lo} is the working pair.
module mdu_step #(
  parameter int n = 32
) (
  input  logic         is_div_i,
  input  logic [n-1:0] hi_i,
  input  logic [n-1:0] lo_i,
  input  logic [n-1:0] opnd_i,
  output logic [n-1:0] hi_o,
  output logic [n-1:0] lo_o
);

  logic [n:0] sum_s;
  logic [n:0] shifted_s;
  logic [n:0] diff_s;

  // single iteration: MUL adds the multiplicand when the current multiplier bit is set
  // then shifts right; DIV shifts the next dividend bit into the remainder and subtracts if it fits
  always_comb begin
    hi_o      = hi_i;
    lo_o      = lo_i;
    sum_s     = {(n+1){1'b0}};
    shifted_s = {(n+1){1'b0}};
    diff_s    = {(n+1){1'b0}};
    if (is_div_i) begin
      shifted_s = {hi_i, lo_i[n-1]};
      diff_s    = shifted_s - {1'b0, opnd_i};
      // a zero divisor always "fits", giving all-ones quotient and remainder = dividend
      if (shifted_s >= {1'b0, opnd_i}) begin
        hi_o = diff_s[n-1:0];
        lo_o = {lo_i[n-2:0], 1'b1};
      end else begin
        hi_o = shifted_s[n-1:0];
        lo_o = {lo_i[n-2:0], 1'b0};
      end
    end else begin
      sum_s        = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(n+1){1'b0}});
      {hi_o, lo_o} = {sum_s, lo_i[n-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: start/busy/done handshake, n iterations
// per operation, result and destination index presented to the register file write port.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int n = 32,
  parameter int r = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] srcA,
  input  logic [n-1:0] srcB,
  input  logic [r-1:0] destReg,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic [r-1:0] resultReg,
  output logic         regWrite
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     op_q, op_d;
  logic [n-1:0]   opnd_q, opnd_d;
  logic [n-1:0]   hi_q, hi_d;
  logic [n-1:0]   lo_q, lo_d;
  logic [r-1:0]   dest_q, dest_d;
  logic [n-1:0]   result_q, result_d;
  logic [r-1:0]   result_reg_q, result_reg_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           accept_s;
  logic [n-1:0]   step_hi_s;
  logic [n-1:0]   step_lo_s;

  function automatic logic [n-1:0] pick_result(input logic [1:0] sel,
                                               input logic [n-1:0] hi,
                                               input logic [n-1:0] lo);
    logic [n-1:0] res;
    case (sel)
      OP_MULLO: res = lo;
      OP_MULHI: res = hi;
      OP_DIVU:  res = lo;
      OP_REMU:  res = hi;
      default:  res = {n{1'b0}};
    endcase
    return res;
  endfunction

  mdu_step #(.n(n)) u_step (
    .is_div_i (op_q[1]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi_s),
    .lo_o     (step_lo_s)
  );

  // next-state, iteration and output-capture logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    opnd_d       = opnd_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dest_d       = dest_q;
    result_d     = result_q;
    result_reg_d = result_reg_q;
    accept_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        hi_d    = step_hi_s;
        lo_d    = step_lo_s;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d      = DONE;
          result_d     = pick_result(op_q, step_hi_s, step_lo_s);
          result_reg_d = dest_q;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (start) begin
          accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // multiply keeps the multiplicand as addend and shifts the multiplier through lo;
    // divide shifts the dividend out of lo and subtracts the divisor
    if (accept_s) begin
      state_d = CALC;
      op_d    = op;
      dest_d  = destReg;
      count_d = {CW{1'b0}};
      hi_d    = {n{1'b0}};
      if (op[1]) begin
        opnd_d = srcB;
        lo_d   = srcA;
      end else begin
        opnd_d = srcA;
        lo_d   = srcB;
      end
    end else begin
      op_d = op_q;
    end

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= {CW{1'b0}};
      op_q         <= 2'b00;
      opnd_q       <= {n{1'b0}};
      hi_q         <= {n{1'b0}};
      lo_q         <= {n{1'b0}};
      dest_q       <= {r{1'b0}};
      result_q     <= {n{1'b0}};
      result_reg_q <= {r{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_q         <= op_d;
      opnd_q       <= opnd_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dest_q       <= dest_d;
      result_q     <= result_d;
      result_reg_q <= result_reg_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign regWrite  = done_q;
  assign result    = result_q;
  assign resultReg = result_reg_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results queued at issue, popped on done.
module tb_mul_div_unit;

  localparam logic [1:0] T_MULLO = 2'b00;
  localparam logic [1:0] T_MULHI = 2'b01;
  localparam logic [1:0] T_DIVU  = 2'b10;
  localparam logic [1:0] T_REMU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [6:0]  destReg;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [6:0]  resultReg;
  logic        regWrite;

  typedef struct {
    logic [31:0] res;
    logic [6:0]  dreg;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  int   edges;
  int   busy_cycles;

  mul_div_unit #(.n(32), .r(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .destReg   (destReg),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .resultReg (resultReg),
    .regWrite  (regWrite)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      T_MULLO: return p[31:0];
      T_MULHI: return p[63:32];
      T_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // output monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && (done || regWrite)) begin
      check_eq("regwrite_eq_done", {63'd0, regWrite}, {63'd0, done});
    end
    if (!reset && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("result", {32'd0, result}, {32'd0, e.res});
        check_eq("resultReg", {57'd0, resultReg}, {57'd0, e.dreg});
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] d, input logic [31:0] e);
    exp_t x;
    start = 1'b1; op = o; srcA = a; srcB = b; destReg = d;
    x.res = e; x.dreg = d;
    sb_q.push_back(x);
  endtask

  // waits from the sampling edge to done; optional mid-operation disturbance
  task automatic wait_done(input bit perturb);
    @(posedge clk); #1;
    edges = 1;
    busy_cycles = busy ? 1 : 0;
    start = 1'b0;
    while (!done && edges < 100) begin
      if (perturb && edges == 5) begin
        start = 1'b1; srcA = 32'd99; srcB = 32'd0; op = T_DIVU; destReg = 7'd1;
      end else if (perturb && edges == 6) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cycles++;
    end
    check_eq("latency", edges, 64'd33);
    check_eq("busy_cycles", busy_cycles, 64'd32);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] d, input logic [31:0] e);
    @(negedge clk);
    issue(o, a, b, d, e);
    wait_done(1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    reset = 1'b1; start = 1'b0; op = 2'b00; srcA = 32'd0; srcB = 32'd0; destReg = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_regwrite", {63'd0, regWrite}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    check_eq("rst_resultReg", {57'd0, resultReg}, 64'd0);
    @(negedge clk); reset = 1'b0;

    run_op(T_MULLO, 32'd7, 32'd6, 7'd5, 32'd42);
    run_op(T_MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd10, 32'h0000_0001);
    run_op(T_MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd11, 32'hFFFF_FFFE);
    run_op(T_DIVU, 32'd100, 32'd7, 7'd12, 32'd14);
    run_op(T_REMU, 32'd100, 32'd7, 7'd13, 32'd2);
    run_op(T_DIVU, 32'd5, 32'd0, 7'd14, 32'hFFFF_FFFF);
    run_op(T_REMU, 32'd5, 32'd0, 7'd15, 32'd5);

    // inputs disturbed mid-operation must be ignored
    dc = done_cnt;
    @(negedge clk);
    issue(T_MULLO, 32'd3, 32'd4, 7'd20, 32'd12);
    wait_done(1'b1);
    repeat (40) @(posedge clk);
    #1;
    check_eq("single_done", done_cnt - dc, 64'd1);

    // reset mid-DIVU discards the operation
    @(negedge clk);
    issue(T_DIVU, 32'd1000, 32'd3, 7'd21, 32'd333);
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_done", {63'd0, done}, 64'd0);
    check_eq("midrst_result", {32'd0, result}, 64'd0);
    check_eq("midrst_resultReg", {57'd0, resultReg}, 64'd0);
    sb_q.delete();
    @(negedge clk); reset = 1'b0;
    dc = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check_eq("no_done_after_rst", done_cnt - dc, 64'd0);
    run_op(T_DIVU, 32'd1000, 32'd3, 7'd22, 32'd333);

    // back-to-back: start held during the DONE cycle
    @(negedge clk);
    issue(T_DIVU, 32'd9, 32'd3, 7'd23, 32'd3);
    wait_done(1'b0);
    issue(T_MULLO, 32'd2, 32'd3, 7'd24, 32'd6);
    wait_done(1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom >> (i * 3);
      ro = 2'(i);
      run_op(ro, ra, rb, 7'(i + 40), model(ro, ra, rb));
    end

    repeat (3) @(posedge clk);
    check_eq("scoreboard_empty", sb_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
